maq_h: RTL and testbench
========================

// Module: maq_h
// PURPOSE
// - Hour stage of the clock chain; consumes the minute stage's carry (inc_hora) and produces the hour digits.
// - Keeps a 24h BCD hour count (00..23) and presents it as 24h or 12h+PM display digits.
// - Time-set mode: count held, hour adjusted by up/down buttons.
// - Generates a day carry (inc_dia) for a later day/date stage.
// PARAMETERS
// - SYNC_STAGES  2  flip-flop depth of the input synchronizers for the set/up/down inputs (>=2)
// - HORA_RESET   0  hour value loaded at reset, 24h format (0..23)
// PORTS
// - maq_m_clock     in   1  clock, rising edge (same clock as the minute stage)
// - maq_m_reset     in   1  reset, asynchronous, active-low
// - maq_h_inc_hora  in   1  minute carry; high for exactly the cycle the minutes read 59
// - maq_h_set       in   1  asynchronous level; 1 = request set mode
// - maq_h_btn_up    in   1  asynchronous level; each rising edge = +1 hour while in SET
// - maq_h_btn_dn    in   1  asynchronous level; each rising edge = -1 hour while in SET
// - maq_h_mode12    in   1  display format: 0 = 24h, 1 = 12h
// - maq_h_lsd       out  4  display hour units, BCD 0..9
// - maq_h_msd       out  2  display hour tens: 0..2 (24h), 0..1 (12h)
// - maq_h_pm        out  1  1 = count is 12..23; valid in both modes
// - maq_h_setting   out  1  1 = FSM is in SET
// - maq_h_inc_dia   out  1  day carry, combinational
// BEHAVIOUR
// - Reset (async, any time, including mid-adjust):
//   - Count = HORA_RESET; FSM = RUN; synchronizers and edge-detect history cleared to 0.
//   - Outputs: lsd/msd/pm show HORA_RESET in the current format; setting = 0; inc_dia = 0.
// - Internal count:
//   - Two BCD registers, cnt_lsd[3:0] and cnt_msd[1:0]; legal range 00..23 only.
//   - Units wrap 9->0 with tens+1.
//   - 23 +1 -> 00; 00 -1 -> 23; x0 -1 -> (x-1)9.
// - Set/up/down inputs:
//   - Each input passes through SYNC_STAGES flip-flops.
//   - up/dn are then rising-edge detected, giving one-cycle pulses.
//   - Latency: input change to internal effect = SYNC_STAGES+1 cycles.
// - FSM, two states:
//   - RUN: each cycle with inc_hora = 1, count +1 (same edge as the minute 59->00 wrap). Up/dn pulses ignored.
//     - RUN -> SET when synchronized set = 1.
//   - SET: inc_hora ignored (minute carries while setting are discarded).
//     - up pulse: count +1. dn pulse: count -1. Both in the same cycle: no change.
//     - SET -> RUN when synchronized set = 0.
//     - Pulses arriving in the cycle of the transition are decided by the current state.
// - inc_dia = (state==RUN) & inc_hora & (count==23).
//   - Exactly one pulse per day, coincident with 23->00.
//   - Never asserted in SET.
// - Display path: registered from count and maq_h_mode12; 1-cycle latency after the count or the mode changes.
//   - 24h: digits = count.
//   - 12h mapping:
//     - 00 -> 12
//     - 01..11 -> unchanged
//     - 12 -> 12
//     - 13..23 -> count-12 (BCD-correct, e.g. 20 -> 08)
//   - pm = (count >= 12); registered alongside the digits.
// - setting = registered state bit; no extra delay.
// STRUCTURE
// - Package maq_pkg:
//   - typedef enum logic {RUN, SET} maq_h_state_t
//   - localparams HORA_MAX_MSD=2, HORA_MAX_LSD=3, HORA_MEIO_DIA=12
//   - function bcd_to_12h()
// - Sub-module maq_h_btn_sync (SYNC_STAGES synchronizer + rising-edge pulse output, async reset).
//   - 3 instances: set (level output used), up, dn.
// - Top level holds the FSM, the BCD counter and the display register.
// TESTING
// - Reset with HORA_RESET=0, mode12=0 -> lsd=0, msd=0, pm=0, setting=0; mode12=1 -> digits show 12, pm=0.
// - RUN, count 23, pulse inc_hora 1 cycle -> inc_dia=1 that cycle; next edge count 00; display 00 one cycle later.
// - mode12=1, count 13 -> display 01, pm=1; count 12 -> display 12, pm=1; count 20 -> display 08, pm=1.
// - set=1 held; after sync, setting=1; dn edge at 00 -> 23; up edge at 23 -> 00; inc_hora pulses -> no change, inc_dia=0.
// - In SET, up and dn rising in the same cycle -> count unchanged; set released -> setting=0, inc_hora counts again.
// - Reset asserted mid-SET at count 17 -> immediate count=HORA_RESET, setting=0; no spurious edge pulse after release.

Source files
------------

// File: rtl/maq_pkg.sv
// -----------------------------------------------------------------------------
// maq_pkg
// Shared types and helpers for the hour stage of the clock chain.
//   maq_h_state_t : RUN (count follows the minute carry) / SET (manual adjust)
//   maq_h_disp_t  : one set of display digits plus the PM flag
//   bcd_to_12h()  : converts a 24h BCD hour into 24h or 12h display digits
// -----------------------------------------------------------------------------
package maq_pkg;

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } maq_h_state_t;

    // Last legal hour is 23: tens digit 2, units digit 3.
    localparam logic [1:0] HORA_MAX_MSD  = 2'd2;
    localparam logic [3:0] HORA_MAX_LSD  = 4'd3;
    localparam int         HORA_MEIO_DIA = 12;

    typedef struct packed {
        logic [1:0] msd;
        logic [3:0] lsd;
        logic       pm;
    } maq_h_disp_t;

    // Maps a BCD hour (00..23) to display digits. With mode12 = 0 the digits
    // are passed through; with mode12 = 1, 00 becomes 12 and 13..23 drop by 12.
    // pm is always derived from the 24h value.
    function automatic maq_h_disp_t bcd_to_12h(input logic [1:0] msd,
                                               input logic [3:0] lsd,
                                               input logic       mode12);
        logic [4:0]  h;
        logic [4:0]  h_out;
        maq_h_disp_t r;
        h     = 5'(msd) * 5'd10 + 5'(lsd);
        r.pm  = (h >= 5'(HORA_MEIO_DIA));
        h_out = h;
        if (mode12) begin
            if (h == 5'd0) begin
                h_out = 5'(HORA_MEIO_DIA);
            end else if (h > 5'(HORA_MEIO_DIA)) begin
                h_out = h - 5'(HORA_MEIO_DIA);
            end
        end
        // Back to BCD with plain compare/subtract; h_out never exceeds 23.
        if (h_out >= 5'd20) begin
            r.msd = 2'd2;
            r.lsd = 4'(h_out - 5'd20);
        end else if (h_out >= 5'd10) begin
            r.msd = 2'd1;
            r.lsd = 4'(h_out - 5'd10);
        end else begin
            r.msd = 2'd0;
            r.lsd = 4'(h_out);
        end
        return r;
    endfunction

endpackage

// File: rtl/maq_h_btn_sync.sv
// -----------------------------------------------------------------------------
// maq_h_btn_sync
// Brings one asynchronous level input into the maq_m_clock domain through a
// SYNC_STAGES flip-flop chain and produces a one-cycle pulse on each rising edge
// of the synchronized level.
// Ports:
//   maq_m_clock  in   clock, rising edge
//   maq_m_reset  in   asynchronous active-low reset (clears chain and history)
//   din          in   asynchronous level
//   level        out  synchronized level
//   rise         out  one-cycle pulse when the synchronized level goes 0 -> 1
// -----------------------------------------------------------------------------
module maq_h_btn_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic maq_m_clock,
    input  logic maq_m_reset,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge maq_m_clock or negedge maq_m_reset) begin
        if (!maq_m_reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    // Combinational so the pulse acts on the edge right after the level
    // appears, giving SYNC_STAGES+1 cycles from input to counter effect.
    assign rise  = level & ~prev_q;

endmodule

// File: rtl/maq_h.sv
// -----------------------------------------------------------------------------
// maq_h
// Hour stage of the clock chain. Counts hours 00..23 in BCD on the minute
// carry, allows manual adjustment in set mode, and drives 24h or 12h+PM
// display digits plus the day carry for the following stage.
// Parameters:
//   SYNC_STAGES  synchronizer depth for set/up/down (>= 2)
//   HORA_RESET   hour loaded at reset, 24h format (0..23)
// Ports:
//   maq_m_clock     in   clock, rising edge
//   maq_m_reset     in   asynchronous active-low reset
//   maq_h_inc_hora  in   minute carry, high during the minute-59 cycle
//   maq_h_set       in   async level, 1 requests set mode
//   maq_h_btn_up    in   async level, rising edge = +1 hour in set mode
//   maq_h_btn_dn    in   async level, rising edge = -1 hour in set mode
//   maq_h_mode12    in   display format, 0 = 24h, 1 = 12h
//   maq_h_lsd       out  display hour units (BCD)
//   maq_h_msd       out  display hour tens
//   maq_h_pm        out  1 when the count is 12..23
//   maq_h_setting   out  1 while in set mode
//   maq_h_inc_dia   out  day carry, combinational
// -----------------------------------------------------------------------------
module maq_h
    import maq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HORA_RESET  = 0
) (
    input  logic       maq_m_clock,
    input  logic       maq_m_reset,
    input  logic       maq_h_inc_hora,
    input  logic       maq_h_set,
    input  logic       maq_h_btn_up,
    input  logic       maq_h_btn_dn,
    input  logic       maq_h_mode12,
    output logic [3:0] maq_h_lsd,
    output logic [1:0] maq_h_msd,
    output logic       maq_h_pm,
    output logic       maq_h_setting,
    output logic       maq_h_inc_dia
);

    localparam logic [3:0] RST_LSD = 4'(HORA_RESET % 10);
    localparam logic [1:0] RST_MSD = 2'(HORA_RESET / 10);

    // BCD hour +1 with 23 -> 00 wrap.
    function automatic logic [5:0] hora_inc(input logic [1:0] msd, input logic [3:0] lsd);
        logic [5:0] r;
        if (msd == HORA_MAX_MSD && lsd == HORA_MAX_LSD) begin
            r = 6'd0;
        end else if (lsd == 4'd9) begin
            r = {msd + 2'd1, 4'd0};
        end else begin
            r = {msd, lsd + 4'd1};
        end
        return r;
    endfunction

    // BCD hour -1 with 00 -> 23 wrap.
    function automatic logic [5:0] hora_dec(input logic [1:0] msd, input logic [3:0] lsd);
        logic [5:0] r;
        if (msd == 2'd0 && lsd == 4'd0) begin
            r = {HORA_MAX_MSD, HORA_MAX_LSD};
        end else if (lsd == 4'd0) begin
            r = {msd - 2'd1, 4'd9};
        end else begin
            r = {msd, lsd - 4'd1};
        end
        return r;
    endfunction

    // Input synchronizers
    logic set_lvl;
    logic set_rise_unused;
    logic up_lvl_unused;
    logic up_rise;
    logic dn_lvl_unused;
    logic dn_rise;

    maq_h_btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_set (
        .maq_m_clock (maq_m_clock),
        .maq_m_reset (maq_m_reset),
        .din         (maq_h_set),
        .level       (set_lvl),
        .rise        (set_rise_unused)
    );

    maq_h_btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_up (
        .maq_m_clock (maq_m_clock),
        .maq_m_reset (maq_m_reset),
        .din         (maq_h_btn_up),
        .level       (up_lvl_unused),
        .rise        (up_rise)
    );

    maq_h_btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dn (
        .maq_m_clock (maq_m_clock),
        .maq_m_reset (maq_m_reset),
        .din         (maq_h_btn_dn),
        .level       (dn_lvl_unused),
        .rise        (dn_rise)
    );

    // FSM and BCD hour counter
    maq_h_state_t state_q;
    maq_h_state_t state_d;
    logic [3:0]   cnt_lsd;
    logic [1:0]   cnt_msd;
    logic [3:0]   cnt_lsd_d;
    logic [1:0]   cnt_msd_d;
    logic         at_max;

    assign at_max = (cnt_msd == HORA_MAX_MSD) && (cnt_lsd == HORA_MAX_LSD);

    always_comb begin
        state_d              = state_q;
        {cnt_msd_d, cnt_lsd_d} = {cnt_msd, cnt_lsd};
        case (state_q)
            RUN: begin
                // Button pulses are ignored while running.
                if (maq_h_inc_hora) begin
                    {cnt_msd_d, cnt_lsd_d} = hora_inc(cnt_msd, cnt_lsd);
                end
                if (set_lvl) begin
                    state_d = SET;
                end
            end
            SET: begin
                // Minute carries are discarded; up and down together cancel.
                if (up_rise && !dn_rise) begin
                    {cnt_msd_d, cnt_lsd_d} = hora_inc(cnt_msd, cnt_lsd);
                end else if (dn_rise && !up_rise) begin
                    {cnt_msd_d, cnt_lsd_d} = hora_dec(cnt_msd, cnt_lsd);
                end
                if (!set_lvl) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge maq_m_clock or negedge maq_m_reset) begin
        if (!maq_m_reset) begin
            state_q <= RUN;
            cnt_lsd <= RST_LSD;
            cnt_msd <= RST_MSD;
        end else begin
            state_q <= state_d;
            cnt_lsd <= cnt_lsd_d;
            cnt_msd <= cnt_msd_d;
        end
    end

    assign maq_h_setting = (state_q == SET);
    assign maq_h_inc_dia = (state_q == RUN) && maq_h_inc_hora && at_max;

    // Display register stage (p1)
    maq_h_disp_t disp_p1;
    logic        vld_p1;
    maq_h_disp_t disp_rst;
    maq_h_disp_t disp_out;

    always_ff @(posedge maq_m_clock) begin
        disp_p1 <= bcd_to_12h(cnt_msd, cnt_lsd, maq_h_mode12);
    end

    always_ff @(posedge maq_m_clock or negedge maq_m_reset) begin
        if (!maq_m_reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= 1'b1;
        end
    end

    // Until the display register has been loaded once after reset, show the
    // reset hour directly so the outputs follow the format input during reset.
    assign disp_rst = bcd_to_12h(RST_MSD, RST_LSD, maq_h_mode12);
    assign disp_out = vld_p1 ? disp_p1 : disp_rst;

    assign maq_h_lsd = disp_out.lsd;
    assign maq_h_msd = disp_out.msd;
    assign maq_h_pm  = disp_out.pm;

endmodule

// File: tb/tb_maq_h.sv
module tb_maq_h;

    localparam int S  = 2;
    localparam int HR = 0;

    logic       clk;
    logic       rst_n;
    logic       inc_hora;
    logic       set_in;
    logic       up;
    logic       dn;
    logic       mode12;
    logic [3:0] lsd;
    logic [1:0] msd;
    logic       pm;
    logic       setting;
    logic       inc_dia;

    maq_h #(.SYNC_STAGES(S), .HORA_RESET(HR)) dut (
        .maq_m_clock    (clk),
        .maq_m_reset    (rst_n),
        .maq_h_inc_hora (inc_hora),
        .maq_h_set      (set_in),
        .maq_h_btn_up   (up),
        .maq_h_btn_dn   (dn),
        .maq_h_mode12   (mode12),
        .maq_h_lsd      (lsd),
        .maq_h_msd      (msd),
        .maq_h_pm       (pm),
        .maq_h_setting  (setting),
        .maq_h_inc_dia  (inc_dia)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: hour as a plain integer, set mode as a flag, and a
    // delay line of raw input samples standing in for the synchronizers.
    int         m_h;
    bit         m_set;
    bit         m_vld;
    logic [6:0] m_disp;
    logic [S+1:0] hs, hu, hd;

    typedef struct {
        int hour;
        bit m12;
        int e_msd;
        int e_lsd;
        int e_pm;
    } vec_t;
    vec_t tbl[10];

    // {msd[1:0], lsd[3:0], pm}
    function automatic logic [6:0] fmt(input int h, input logic m12);
        int d;
        d = h;
        if (m12) d = (h % 12 == 0) ? 12 : h % 12;
        return {2'(d / 10), 4'(d % 10), (h >= 12)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_h   = HR;
        m_set = 1'b0;
        m_vld = 1'b0;
        hs    = '0;
        hu    = '0;
        hd    = '0;
    endtask

    task automatic model_edge();
        int dlt;
        hs = {hs[S:0], set_in};
        hu = {hu[S:0], up};
        hd = {hd[S:0], dn};
        m_disp = fmt(m_h, mode12);
        m_vld  = 1'b1;
        if (!m_set) begin
            if (inc_hora) m_h = (m_h + 1) % 24;
            if (hs[S]) m_set = 1'b1;
        end else begin
            dlt = int'(hu[S] & ~hu[S+1]) - int'(hd[S] & ~hd[S+1]);
            m_h = (m_h + dlt + 24) % 24;
            if (!hs[S]) m_set = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic [6:0] d;
        d = m_vld ? m_disp : fmt(HR, mode12);
        check("msd",     int'(msd),     int'(d[6:5]));
        check("lsd",     int'(lsd),     int'(d[4:1]));
        check("pm",      int'(pm),      int'(d[0]));
        check("setting", int'(setting), int'(m_set));
        check("inc_dia", int'(inc_dia), int'(!m_set && inc_hora && m_h == 23));
    endtask

    // Inputs are driven at the falling edge before calling this.
    task automatic cycle();
        #1;
        compare_all();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    task automatic hw_reset();
        rst_n = 1'b0;
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic check_disp(input string name, input int e_msd, input int e_lsd, input int e_pm);
        check({name, "_msd"}, int'(msd), e_msd);
        check({name, "_lsd"}, int'(lsd), e_lsd);
        check({name, "_pm"},  int'(pm),  e_pm);
    endtask

    initial begin
        tbl[0] = '{hour: 0,  m12: 1'b0, e_msd: 0, e_lsd: 0, e_pm: 0};
        tbl[1] = '{hour: 0,  m12: 1'b1, e_msd: 1, e_lsd: 2, e_pm: 0};
        tbl[2] = '{hour: 13, m12: 1'b1, e_msd: 0, e_lsd: 1, e_pm: 1};
        tbl[3] = '{hour: 12, m12: 1'b1, e_msd: 1, e_lsd: 2, e_pm: 1};
        tbl[4] = '{hour: 20, m12: 1'b1, e_msd: 0, e_lsd: 8, e_pm: 1};
        tbl[5] = '{hour: 23, m12: 1'b0, e_msd: 2, e_lsd: 3, e_pm: 1};
        tbl[6] = '{hour: 11, m12: 1'b1, e_msd: 1, e_lsd: 1, e_pm: 0};
        tbl[7] = '{hour: 9,  m12: 1'b0, e_msd: 0, e_lsd: 9, e_pm: 0};
        tbl[8] = '{hour: 19, m12: 1'b1, e_msd: 0, e_lsd: 7, e_pm: 1};
        tbl[9] = '{hour: 10, m12: 1'b1, e_msd: 1, e_lsd: 0, e_pm: 0};

        inc_hora = 1'b0;
        set_in   = 1'b0;
        up       = 1'b0;
        dn       = 1'b0;
        mode12   = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset state in both formats
        cycle();
        #1;
        check_disp("rst24", 0, 0, 0);
        check("rst_setting", int'(setting), 0);
        check("rst_inc_dia", int'(inc_dia), 0);
        mode12 = 1'b1;
        #1;
        check_disp("rst12", 1, 2, 0);
        @(negedge clk);
        mode12 = 1'b0;
        rst_n  = 1'b1;

        // Display mapping table
        for (int i = 0; i < 10; i++) begin
            hw_reset();
            mode12   = tbl[i].m12;
            inc_hora = 1'b1;
            repeat (tbl[i].hour) cycle();
            inc_hora = 1'b0;
            repeat (2) cycle();
            #1;
            check_disp($sformatf("tbl%0d", i), tbl[i].e_msd, tbl[i].e_lsd, tbl[i].e_pm);
            @(negedge clk);
        end

        // Day rollover
        hw_reset();
        mode12   = 1'b0;
        inc_hora = 1'b1;
        repeat (23) cycle();
        inc_hora = 1'b0;
        cycle();
        inc_hora = 1'b1;
        #1;
        check("dia_pulse", int'(inc_dia), 1);
        cycle();
        inc_hora = 1'b0;
        #1;
        check("dia_after", int'(inc_dia), 0);
        check_disp("roll_lag", 2, 3, 1);
        cycle();
        check_disp("roll_00", 0, 0, 0);

        // Set mode: entry latency, wrap both ways, carries ignored
        hw_reset();
        set_in = 1'b1;
        repeat (S) cycle();
        check("set_early", int'(setting), 0);
        cycle();
        check("set_entered", int'(setting), 1);
        dn = 1'b1;
        repeat (S + 2) cycle();
        check_disp("dn_wrap", 2, 3, 1);
        dn = 1'b0;
        repeat (3) cycle();
        up = 1'b1;
        repeat (S + 2) cycle();
        check_disp("up_wrap", 0, 0, 0);
        up = 1'b0;
        repeat (3) cycle();
        dn = 1'b1;
        repeat (S + 2) cycle();
        dn = 1'b0;
        repeat (3) cycle();
        inc_hora = 1'b1;
        #1;
        check("set_no_dia", int'(inc_dia), 0);
        repeat (4) cycle();
        inc_hora = 1'b0;
        cycle();
        check_disp("set_hold", 2, 3, 1);
        up = 1'b1;
        dn = 1'b1;
        repeat (S + 3) cycle();
        check_disp("both_btn", 2, 3, 1);
        up = 1'b0;
        dn = 1'b0;
        repeat (2) cycle();
        set_in = 1'b0;
        repeat (S) cycle();
        check("set_still", int'(setting), 1);
        cycle();
        check("set_left", int'(setting), 0);
        inc_hora = 1'b1;
        #1;
        check("run_dia", int'(inc_dia), 1);
        cycle();
        inc_hora = 1'b0;
        repeat (2) cycle();
        check_disp("run_again", 0, 0, 0);

        // Reset in the middle of set mode at 17
        hw_reset();
        set_in = 1'b1;
        repeat (S + 1) cycle();
        for (int k = 0; k < 17; k++) begin
            up = 1'b1;
            cycle();
            up = 1'b0;
            cycle();
        end
        repeat (S + 2) cycle();
        check_disp("at17", 1, 7, 1);
        check("at17_setting", int'(setting), 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_setting", int'(setting), 0);
        check_disp("mid_rst", 0, 0, 0);
        set_in = 1'b0;
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
        repeat (S + 3) cycle();
        check_disp("post_rst", 0, 0, 0);
        check("post_rst_setting", int'(setting), 0);

        // Randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            inc_hora = ($urandom % 4 == 0);
            if ($urandom % 40 == 0) set_in = ~set_in;
            if ($urandom % 3 == 0) up = ~up;
            if ($urandom % 3 == 0) dn = ~dn;
            if ($urandom % 50 == 0) mode12 = ~mode12;
            if ($urandom % 500 == 0) begin
                #3;
                rst_n = 1'b0;
                model_reset();
                @(negedge clk);
                cycle();
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
